// File: rtl/dcm_spi_pkg.sv
// Shared types and constants for the dcmctrl SPI initiator.
// SPI mode 0, MSB first, 8-bit frames.
package dcm_spi_pkg;

    localparam int unsigned SPI_CPOL   = 0;
    localparam int unsigned SPI_CPHA   = 0;
    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/dcm_spi_clkgen.sv
// SCLK strobe generator: alternating rise/fall strobes every CLK_DIV cycles while enabled.
// The first strobe after enable is always a rise.
module dcm_spi_clkgen
    import dcm_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;
    logic             tick;

    assign tick     = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign rise_stb = tick && !phase_q;
    assign fall_stb = tick && phase_q;

    // Holding the count cleared while disabled gives a fresh phase on every enable rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dcm_spi_master.sv
// SPI mode-0 initiator for the dcmctrl slave port: start/len command, tx valid/ready
// byte stream in, rx valid byte stream out, plus a synchronized copy of the slave irq.
module dcm_spi_master
    import dcm_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned LEN_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             spi_ss,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    input  logic             irq_in,
    output logic             irq_sync
);

    localparam int unsigned TMR_MAX   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam logic        SCLK_IDLE = 1'(SPI_CPOL);

    spi_state_e                state_q, state_d;
    logic [LEN_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [SPI_BYTE_W-2:0]     tx_sr_q, tx_sr_d;
    logic [SPI_BYTE_W-1:0]     rx_sr_q, rx_sr_d;
    logic [SPI_BYTE_W-1:0]     rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      ss_q, ss_d;
    logic                      sclk_q, sclk_d;
    logic                      mosi_q, mosi_d;
    logic                      irq_meta_q, irq_sync_q;
    logic                      shift_en, rise_stb, fall_stb;

    dcm_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk     (clk),
        .reset   (reset),
        .en      (shift_en),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tmr_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ss_q       <= 1'b1;
            sclk_q     <= SCLK_IDLE;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tmr_q      <= tmr_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tmr_d      = tmr_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        byte_cnt_d = len;
                        busy_d     = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        done_d     = 1'b1;
                    end
                end
            end
            LOAD: begin
                // spi_ss still high means this is the first byte of the frame.
                if (tx_valid) begin
                    tx_sr_d   = tx_data[SPI_BYTE_W-2:0];
                    mosi_d    = tx_data[SPI_BYTE_W-1];
                    bit_cnt_d = '0;
                    if (ss_q) begin
                        ss_d    = 1'b0;
                        tmr_d   = '0;
                        state_d = SETUP;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SETUP: begin
                if (tmr_q == TMR_W'(CS_SETUP - 1)) state_d = SHIFT;
                else                               tmr_d   = tmr_q + 1'b1;
            end
            SHIFT: begin
                if (rise_stb) begin
                    sclk_d  = ~SCLK_IDLE;
                    rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], spi_miso};
                end else if (fall_stb) begin
                    sclk_d = SCLK_IDLE;
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        mosi_d    = tx_sr_q[SPI_BYTE_W-2];
                        tx_sr_d   = {tx_sr_q[SPI_BYTE_W-3:0], 1'b0};
                    end else begin
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        byte_cnt_d = byte_cnt_q - 1'b1;
                        if (byte_cnt_q == LEN_W'(1)) begin
                            tmr_d   = '0;
                            state_d = HOLD;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state_q == LOAD);
        shift_en = (state_q == SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= irq_in;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_ss   = ss_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign irq_sync = irq_sync_q;

endmodule

// File: tb/tb_dcm_spi_master.sv
// Scoreboard bench for dcm_spi_master: expected rx bytes are queued at stimulus time
// and checked by an independent monitor; frame timing is checked from counters.
module tb_dcm_spi_master;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned BYTE_CYC = 16 * CLK_DIV;

    logic             clk, reset, start;
    logic [LEN_W-1:0] len;
    logic             busy, done;
    logic [7:0]       tx_data;
    logic             tx_valid, tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             spi_ss, spi_clk, spi_mosi, spi_miso;
    logic             irq_in, irq_sync;

    logic             loopback, glitch_en, glitch;
    logic [7:0]       slave_sr;
    logic [7:0]       tx_q[$];
    logic [7:0]       exp_q[$];

    int n_checks, n_fail;
    int ss_low, sclk_rise, rx_cnt, done_cnt, busy_cnt, mosi_high;
    logic prev_sclk, busy_prev, busy_at_done, busy_before_done;

    assign spi_miso = loopback ? spi_mosi : (slave_sr[7] ^ glitch);

    dcm_spi_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .LEN_W   (LEN_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .spi_ss  (spi_ss),
        .spi_clk (spi_clk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .irq_in  (irq_in),
        .irq_sync(irq_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counters();
        @(posedge clk);
        #1;
        ss_low = 0; sclk_rise = 0; rx_cnt = 0; done_cnt = 0; busy_cnt = 0; mosi_high = 0;
    endtask

    task automatic pulse_start(input logic [LEN_W-1:0] l);
        tick();
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (done_cnt != 0) break;
        end
        tick();
        tick();
        check(name, done_cnt, 1);
    endtask

    // tx source: presents the queue head; pops when the next edge will consume it
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (tx_q.size() != 0) begin
                tx_valid = 1'b1;
                tx_data  = tx_q[0];
                if (tx_ready) void'(tx_q.pop_front());
            end else begin
                tx_valid = 1'b0;
            end
        end
    end

    // slave model: shifts on SCLK fall, corrupts MISO mid-high-phase when enabled
    initial begin
        glitch = 1'b0;
        forever begin
            @(posedge spi_clk);
            repeat (2) @(posedge clk);
            glitch = glitch_en;
            @(negedge spi_clk);
            glitch   = 1'b0;
            slave_sr = {slave_sr[6:0], 1'b0};
        end
    end

    initial begin
        prev_sclk = 1'b0;
        busy_prev = 1'b0;
        busy_at_done = 1'b0;
        busy_before_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!spi_ss) ss_low++;
            if (spi_clk && !prev_sclk) sclk_rise++;
            prev_sclk = spi_clk;
            if (rx_valid) rx_cnt++;
            if (spi_mosi) mosi_high++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                busy_at_done     = busy;
                busy_before_done = busy_prev;
            end
            busy_prev = busy;
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", {24'h0, rx_data}, {24'h0, e});
                end
            end
        end
    end

    initial begin
        int bad_clk, bad_ss, bad_rdy;
        logic [7:0] irq_trace;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; len = '0; irq_in = 1'b0;
        loopback = 1'b1; glitch_en = 1'b0; slave_sr = '0;
        ss_low = 0; sclk_rise = 0; rx_cnt = 0; done_cnt = 0; busy_cnt = 0; mosi_high = 0;

        repeat (3) tick();
        check("rst_ss", spi_ss, 1);
        check("rst_sclk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_irq_sync", irq_sync, 0);
        reset = 1'b0;
        repeat (2) tick();

        // loopback, two bytes, source never stalls
        clear_counters();
        tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        pulse_start(2);
        wait_done("lb_done_once");
        check("lb_ss_low", ss_low, CS_SETUP + 2 * BYTE_CYC + 1 + CS_HOLD);
        check("lb_sclk_rises", sclk_rise, 16);
        check("lb_rx_count", rx_cnt, 2);
        check("lb_busy_at_done", busy_at_done, 0);
        check("lb_busy_before_done", busy_before_done, 1);
        check("lb_idle_ss", spi_ss, 1);

        // slave returns 0x81, MOSI sends 0x00, MISO disturbed while SCLK is high
        loopback = 1'b0; slave_sr = 8'h81; glitch_en = 1'b1;
        clear_counters();
        tx_q.push_back(8'h00);
        exp_q.push_back(8'h81);
        pulse_start(1);
        wait_done("slv_done_once");
        check("slv_mosi_high", mosi_high, 0);
        check("slv_rx_data_hold", rx_data, 8'h81);
        check("slv_rx_count", rx_cnt, 1);
        glitch_en = 1'b0; loopback = 1'b1;

        // tx_valid withheld for 20 cycles before byte 2
        clear_counters();
        tx_q.push_back(8'h5A);
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
        pulse_start(2);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!tx_ready) break;
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx_ready) break;
        end
        check("stall_reach_load", tx_ready, 1);
        bad_clk = 0; bad_ss = 0; bad_rdy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (spi_clk !== 1'b0) bad_clk++;
            if (spi_ss !== 1'b0) bad_ss++;
            if (tx_ready !== 1'b1) bad_rdy++;
        end
        check("stall_sclk_low", bad_clk, 0);
        check("stall_ss_low", bad_ss, 0);
        check("stall_tx_ready", bad_rdy, 0);
        tx_q.push_back(8'hC3);
        wait_done("stall_done_once");
        check("stall_rx_count", rx_cnt, 2);
        check("stall_sclk_rises", sclk_rise, 16);
        check("stall_ss_low_total", ss_low, CS_SETUP + 2 * BYTE_CYC + 1 + 21 + CS_HOLD);

        // len = 0: done next cycle, no select, no busy
        clear_counters();
        tick();
        start = 1'b1; len = '0;
        tick();
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        start = 1'b0;
        tick();
        check("len0_done_single", done, 0);
        repeat (5) tick();
        check("len0_ss_never_low", ss_low, 0);
        check("len0_busy_never", busy_cnt, 0);

        // second start during a len=3 frame is ignored
        clear_counters();
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        pulse_start(3);
        repeat (40) tick();
        pulse_start(5);
        wait_done("busy_start_done");
        check("busy_start_rx_count", rx_cnt, 3);
        check("busy_start_ss_low", ss_low, CS_SETUP + 3 * BYTE_CYC + 2 + CS_HOLD);
        repeat (10) tick();
        check("busy_start_no_rerun", done_cnt, 1);
        check("busy_start_idle", busy, 0);

        // asynchronous reset in the 5th SCLK high phase of byte 1
        clear_counters();
        tx_q.push_back(8'hE7);
        pulse_start(1);
        for (int i = 0; i < 500; i++) begin
            tick();
            if (sclk_rise >= 5) break;
        end
        check("mid_sclk_high", spi_clk, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_ss", spi_ss, 1);
        check("mid_rst_sclk", spi_clk, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        clear_counters();
        tx_q.push_back(8'h96);
        exp_q.push_back(8'h96);
        pulse_start(1);
        wait_done("post_rst_done");
        check("post_rst_rx_count", rx_cnt, 1);
        check("post_rst_ss_low", ss_low, CS_SETUP + BYTE_CYC + CS_HOLD);

        // irq synchronizer: 3-cycle pulse appears 2 cycles later for 3 cycles
        tick();
        irq_in = 1'b1;
        irq_trace = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            irq_trace[i] = irq_sync;
            if (i == 2) irq_in = 1'b0;
        end
        check("irq_trace", irq_trace, 8'b0000_1110);

        repeat (4) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
